// File: rtl/spi_reg_pkg.sv
// Shared definitions for the SPI-to-register-bus bridge.
// Holds the frame opcodes, the FSM state encoding and helpers that derive
// counter widths from the register data width.
package spi_reg_pkg;

   localparam logic [7:0] OP_WRITE = 8'h02;
   localparam logic [7:0] OP_READ  = 8'h03;

   localparam int BYTE_W               = 8;
   localparam int DATA_W_DEFAULT       = 32;
   localparam int BYTES_WORD_DEFAULT   = DATA_W_DEFAULT / BYTE_W;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_CMD,
      ST_ADDR,
      ST_WDATA,
      ST_RD_REQ,
      ST_RD_WAIT,
      ST_RDATA,
      ST_DISCARD
   } state_e;

   // The bit counter must reach both 7 (opcode/address byte) and
   // DATA_W-1 (data word), so it never gets narrower than 3 bits.
   function automatic int bitCntWidth(input int dataW);
      return ($clog2(dataW) < 3) ? 3 : $clog2(dataW);
   endfunction

endpackage

// File: rtl/spi_edge_sync.sv
// Multi-flop synchroniser with rising/falling edge detection for one
// asynchronous input sampled in the clk domain.
// Ports:
//   clk     system clock
//   rst_n   asynchronous active-low reset
//   d_i     asynchronous input
//   q_o     synchronised level
//   rise_o  one-cycle pulse on a synchronised 0->1 transition
//   fall_o  one-cycle pulse on a synchronised 1->0 transition
module spi_edge_sync #(
   parameter int   STAGES    = 2,
   parameter logic RESET_VAL = 1'b0
) (
   input  logic clk,
   input  logic rst_n,
   input  logic d_i,
   output logic q_o,
   output logic rise_o,
   output logic fall_o
);

   logic [STAGES-1:0] sync_q;
   logic              prev_q;

   // Shift the raw input through the synchroniser chain and keep the
   // previous synchronised level for edge detection.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_q <= {STAGES{RESET_VAL}};
         prev_q <= RESET_VAL;
      end else begin
         sync_q <= (sync_q << 1) | STAGES'(d_i);
         prev_q <= sync_q[STAGES-1];
      end
   end

   assign q_o    = sync_q[STAGES-1];
   assign rise_o = sync_q[STAGES-1] & ~prev_q;
   assign fall_o = ~sync_q[STAGES-1] & prev_q;

endmodule

// File: rtl/spi_reg_bridge.sv
// SPI mode-0 target that converts host frames (opcode, address, data words)
// into single-cycle read/write strobes on the register-file bus. All SPI
// pins are oversampled in the clk domain.
// Ports:
//   clk, rst_n           system clock, asynchronous active-low reset
//   spi_sclk/cs_n/mosi   raw SPI inputs from the pins
//   spi_miso, _oe        serial read data and pad output enable
//   reg_addr, reg_wdata  register bus address and write data
//   reg_write, reg_read  one-cycle bus strobes
//   reg_rdata            register read data, valid RD_LATENCY cycles after reg_read
//   busy                 frame active (synchronised cs_n low)
//   frame_err            one-cycle pulse on illegal opcode or truncated frame
module spi_reg_bridge
   import spi_reg_pkg::*;
#(
   parameter int ADDR_W      = 8,
   parameter int DATA_W      = DATA_W_DEFAULT,
   parameter int RD_LATENCY  = 1,
   parameter int SYNC_STAGES = 2
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              spi_sclk,
   input  logic              spi_cs_n,
   input  logic              spi_mosi,
   output logic              spi_miso,
   output logic              spi_miso_oe,
   output logic [ADDR_W-1:0] reg_addr,
   output logic [DATA_W-1:0] reg_wdata,
   output logic              reg_write,
   output logic              reg_read,
   input  logic [DATA_W-1:0] reg_rdata,
   output logic              busy,
   output logic              frame_err
);

   localparam int CNT_W = bitCntWidth(DATA_W);

   logic sclk_level_unused, sclk_rise, sclk_fall;
   logic cs_sync, cs_rise, cs_fall;
   logic mosi_sync;
   logic [1:0] mosi_edge_unused;

   state_e              state_q, state_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic [DATA_W-1:0]   shift_q, shift_d, shift_in;
   logic                is_read_q, is_read_d;
   logic [ADDR_W-1:0]   addr_q, addr_d;
   logic [DATA_W-1:0]   wdata_q, wdata_d;
   logic                write_q, write_d;
   logic                read_q, read_d;
   logic [1:0]          lat_q, lat_d;
   logic                oe_q, oe_d;
   logic                err_q, err_d;
   logic                busy_q, busy_d;
   logic                armed_q, armed_d;
   logic                rise_seen_q, rise_seen_d;

   spi_edge_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_sclk (
      .clk    (clk),
      .rst_n  (rst_n),
      .d_i    (spi_sclk),
      .q_o    (sclk_level_unused),
      .rise_o (sclk_rise),
      .fall_o (sclk_fall)
   );

   // cs_n resets to the asserted level so that a chip select already low
   // when reset is released produces no falling edge: that frame is
   // ignored until cs_n goes high and low again.
   spi_edge_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_cs (
      .clk    (clk),
      .rst_n  (rst_n),
      .d_i    (spi_cs_n),
      .q_o    (cs_sync),
      .rise_o (cs_rise),
      .fall_o (cs_fall)
   );

   spi_edge_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_mosi (
      .clk    (clk),
      .rst_n  (rst_n),
      .d_i    (spi_mosi),
      .q_o    (mosi_sync),
      .rise_o (mosi_edge_unused[0]),
      .fall_o (mosi_edge_unused[1])
   );

   assign shift_in = {shift_q[DATA_W-2:0], mosi_sync};

   // Frame sequencer. Bit edges are processed first; a cs_n rise then
   // overrides the next state so a final edge arriving together with the
   // deselect still completes its word.
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      shift_d     = shift_q;
      is_read_d   = is_read_q;
      addr_d      = addr_q;
      wdata_d     = wdata_q;
      write_d     = 1'b0;
      read_d      = 1'b0;
      lat_d       = lat_q;
      oe_d        = oe_q;
      err_d       = 1'b0;
      rise_seen_d = rise_seen_q;
      armed_d     = armed_q | cs_sync;
      busy_d      = armed_q & ~cs_sync;

      // Address auto-increments the cycle after each write strobe.
      if (write_q) begin
         addr_d = addr_q + 1'b1;
      end

      case (state_q)
         ST_IDLE: begin
            if (cs_fall) begin
               state_d = ST_CMD;
               cnt_d   = '0;
            end
         end
         ST_CMD: begin
            if (sclk_rise) begin
               shift_d = shift_in;
               cnt_d   = cnt_q + 1'b1;
               if (cnt_q == CNT_W'(7)) begin
                  cnt_d = '0;
                  if (shift_in[7:0] == OP_WRITE) begin
                     is_read_d = 1'b0;
                     state_d   = ST_ADDR;
                  end else if (shift_in[7:0] == OP_READ) begin
                     is_read_d = 1'b1;
                     state_d   = ST_ADDR;
                  end else begin
                     err_d   = 1'b1;
                     state_d = ST_DISCARD;
                  end
               end
            end
         end
         ST_ADDR: begin
            if (sclk_rise) begin
               shift_d = shift_in;
               cnt_d   = cnt_q + 1'b1;
               if (cnt_q == CNT_W'(7)) begin
                  cnt_d  = '0;
                  addr_d = ADDR_W'(shift_in[7:0]);
                  if (is_read_q) begin
                     state_d = ST_RD_REQ;
                     oe_d    = 1'b1;
                  end else begin
                     state_d = ST_WDATA;
                  end
               end
            end
         end
         ST_WDATA: begin
            if (sclk_rise) begin
               shift_d = shift_in;
               cnt_d   = cnt_q + 1'b1;
               if (cnt_q == CNT_W'(DATA_W - 1)) begin
                  cnt_d   = '0;
                  wdata_d = shift_in;
                  write_d = 1'b1;
               end
            end
         end
         ST_RD_REQ: begin
            read_d  = 1'b1;
            lat_d   = '0;
            state_d = ST_RD_WAIT;
         end
         ST_RD_WAIT: begin
            // The first wait cycle is the strobe cycle itself, which is
            // when zero-latency read data is valid.
            if (lat_q == 2'(RD_LATENCY)) begin
               shift_d     = reg_rdata;
               cnt_d       = '0;
               rise_seen_d = 1'b0;
               state_d     = ST_RDATA;
            end else begin
               lat_d = lat_q + 1'b1;
            end
         end
         ST_RDATA: begin
            // A falling edge only shifts once the host has sampled the
            // current bit; this skips the stray falling edge that closes
            // the address byte, whose arrival relative to the preload
            // depends on the sclk rate.
            if (sclk_rise) begin
               rise_seen_d = 1'b1;
            end else if (sclk_fall && rise_seen_q) begin
               shift_d     = {shift_q[DATA_W-2:0], 1'b0};
               rise_seen_d = 1'b0;
               cnt_d       = cnt_q + 1'b1;
               if (cnt_q == CNT_W'(DATA_W - 1)) begin
                  cnt_d   = '0;
                  addr_d  = addr_q + 1'b1;
                  state_d = ST_RD_REQ;
               end
            end
         end
         ST_DISCARD: begin
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      // Deselect ends the frame from any state. A byte or word left
      // partially shifted is reported; a read not yet strobed is dropped.
      if (cs_rise) begin
         state_d = ST_IDLE;
         oe_d    = 1'b0;
         read_d  = 1'b0;
         if ((state_q == ST_CMD || state_q == ST_ADDR ||
              state_q == ST_WDATA || state_q == ST_RDATA) && cnt_d != '0) begin
            err_d = 1'b1;
         end
      end
   end

   // State and output registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_IDLE;
         cnt_q       <= '0;
         shift_q     <= '0;
         is_read_q   <= 1'b0;
         addr_q      <= '0;
         wdata_q     <= '0;
         write_q     <= 1'b0;
         read_q      <= 1'b0;
         lat_q       <= '0;
         oe_q        <= 1'b0;
         err_q       <= 1'b0;
         busy_q      <= 1'b0;
         armed_q     <= 1'b0;
         rise_seen_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         shift_q     <= shift_d;
         is_read_q   <= is_read_d;
         addr_q      <= addr_d;
         wdata_q     <= wdata_d;
         write_q     <= write_d;
         read_q      <= read_d;
         lat_q       <= lat_d;
         oe_q        <= oe_d;
         err_q       <= err_d;
         busy_q      <= busy_d;
         armed_q     <= armed_d;
         rise_seen_q <= rise_seen_d;
      end
   end

   // MISO is the shift register MSB, forced low whenever the pad is off.
   assign spi_miso    = oe_q & shift_q[DATA_W-1];
   assign spi_miso_oe = oe_q;
   assign reg_addr    = addr_q;
   assign reg_wdata   = wdata_q;
   assign reg_write   = write_q;
   assign reg_read    = read_q;
   assign busy        = busy_q;
   assign frame_err   = err_q;

endmodule

// File: doc/spi_reg_bridge.md
Name: spi_reg_bridge

Overview:
- SPI mode-0 target that turns host serial frames into single-cycle strobes on the register-file bus (reg_addr/reg_wdata/reg_write/reg_read/reg_rdata).
- It is the initiator side of that bus.
- Sits between the board SPI pins and register_file. All SPI inputs are oversampled in the system clock domain; there is no SCLK clock domain.

Parameters:
- ADDR_W, 8, register address width.
- DATA_W, 32, register data width; must be a multiple of 8.
- RD_LATENCY, 1, clk cycles from reg_read strobe to valid reg_rdata; legal range 0..2.
- SYNC_STAGES, 2, synchroniser depth on sclk/cs_n/mosi.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- spi_sclk  in  1  SPI clock, asynchronous, ≤ clk/8.
- spi_cs_n  in  1  SPI chip select, active low, asynchronous.
- spi_mosi  in  1  host-to-target serial data.
- spi_miso  out  1  target-to-host serial data.
- spi_miso_oe  out  1  MISO output enable (pad tristate control).
- reg_addr  out  ADDR_W  register address.
- reg_wdata  out  DATA_W  register write data.
- reg_write  out  1  one-cycle write strobe.
- reg_read  out  1  one-cycle read strobe.
- reg_rdata  in  DATA_W  register read data.
- busy  out  1  high while a frame is active (cs_n low, synchronised).
- frame_err  out  1  one-cycle pulse on an illegal opcode or a truncated frame.

Behaviour:
- Reset values: spi_miso=0, spi_miso_oe=0, reg_addr=0, reg_wdata=0, reg_write=0, reg_read=0, busy=0, frame_err=0; FSM in IDLE.
- Input conditioning:
  - sclk, cs_n and mosi each pass through SYNC_STAGES flops.
  - Rising/falling edges are detected on synchronised sclk.
  - mosi is sampled on the synchronised rising edge.
  - MISO changes only after the synchronised falling edge, except the first data bit, which is preloaded.
- Frame format, MSB first:
  - Byte 0: opcode. 0x02 = write, 0x03 = read.
  - Byte 1: address.
  - Then N×(DATA_W/8) data bytes. Burst continues while cs_n is low.
- FSM states: IDLE, CMD, ADDR, WDATA, RD_REQ, RD_WAIT, RDATA, DISCARD.
- IDLE → CMD on synchronised cs_n falling. The bit counter clears.
- CMD: after 8 bits:
  - 0x02 → ADDR (write).
  - 0x03 → ADDR (read).
  - Any other value → pulse frame_err and go to DISCARD.
- ADDR: after 8 bits, reg_addr is loaded with the shifted address.
  - Write → WDATA.
  - Read → RD_REQ.
- WDATA: after DATA_W bits:
  - reg_wdata is loaded.
  - reg_write pulses 1 cycle, in the cycle after the last bit's rising edge is detected; reg_addr is stable on that cycle.
  - Next cycle reg_addr increments (wraps at 2^ADDR_W−1 → 0). Stay in WDATA.
- RD_REQ:
  - reg_read pulses 1 cycle.
  - → RD_WAIT, which counts RD_LATENCY cycles (skipped when 0).
  - reg_rdata is then captured into the shift register, bit DATA_W−1 is driven on spi_miso, and the FSM goes to RDATA.
  - The first MISO bit is valid no later than 5+RD_LATENCY clk cycles after the raw address-LSB rising edge. This meets mode-0 setup given sclk ≤ clk/8.
- RDATA:
  - Each synchronised falling edge shifts the next bit out.
  - After DATA_W bits, reg_addr increments (wraps) → RD_REQ for the burst. No reg_read is issued until the final bit of the current word has completed.
- DISCARD: ignore all bits until cs_n rises.
- spi_miso_oe=1 only while busy and the opcode is read, from RD_REQ entry until cs_n rises. spi_miso=0 whenever oe=0.
- cs_n rising (synchronised), in any state → IDLE at the next clk:
  - If it happens mid-byte or mid-word, frame_err pulses. Exception: a rise in CMD with 0 bits received is a clean empty frame and gives no error.
  - No strobe is issued for a partial write word.
  - A read already strobed is not retracted.
- cs_n rising on the same cycle as the final data bit edge: the edge is processed first, so the write completes and then the FSM returns to IDLE without frame_err.
- busy follows synchronised cs_n (inverted), registered.
- Asynchronous reset mid-frame: everything returns to reset values. The FSM restarts only on the next cs_n falling edge; a cs_n that is already low is ignored until it rises.

Decomposition:
- Package spi_reg_pkg:
  - opcode constants OP_WRITE=8'h02, OP_READ=8'h03.
  - state enum typedef.
  - width localparams derived from DATA_W.
- Sub-module spi_edge_sync: synchroniser plus rise/fall detect for one input. Instantiated three times (sclk, cs_n, mosi; edge outputs unused for mosi).

Test Plan:
- Write: frame 02 00 00 00 00 0F → exactly one reg_write pulse, reg_addr=0x00, reg_wdata=0x0000000F; no reg_read; frame_err=0.
- Read: frame 03 01 + 32 dummy clocks with reg_rdata=0x00000011 (RD_LATENCY=1) → one reg_read with reg_addr=0x01; MISO bits reassemble to 0x00000011; oe deasserts after cs_n high.
- Burst write with wrap: 02 FE + words 0x11111111, 0x22222222, 0x33333333 → writes at 0xFE, 0xFF, 0x00 with the matching data.
- Truncated frame: 02 05 + 12 data bits, then cs_n high → no reg_write, one frame_err pulse, busy=0, state IDLE; the next good frame works.
- Illegal opcode 0x55 followed by 40 bits → frame_err pulse once, no strobes, oe stays 0.
- Reset asserted mid read data phase → all outputs return to reset values immediately; the frame is ignored until a cs_n rise/fall, then a normal read returns correct data. Repeat the read test with RD_LATENCY=0 and 2.
